// File: rtl/regfile_initiator.sv
// regfile_initiator
// Command sequencer that owns all access timing to one register file instance.
// Requests arrive over a valid/ready handshake, are executed against the
// register file in a single EXEC cycle, and read results (plus optional write
// acknowledgements) are returned over a second valid/ready channel.
//
// Parameters:
//   N - data width in bits
//   M - number of registers (power of two, >= 2); A = $clog2(M)
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   req_valid/req_ready     - request handshake
//   req_write/addr/wdata    - request type, target register, write data
//   rsp_valid/rsp_ready     - response handshake
//   rsp_write/addr/rdata    - echoed type/address, read data (0 for acks)
//   rf_write_enable/addr/data, rf_read_addr - drive the register file
//   rf_read_data            - combinational read data from the register file
//   txn_count               - completed transactions, saturating at 16'hFFFF
//
// Build option:
//   REGFILE_INIT_WRITE_ACK_EN - when defined, writes return an acknowledgement
//   response; when undefined, writes are posted and return nothing.

module regfile_initiator #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4,
  localparam int unsigned A = $clog2(M)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [A-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [A-1:0] rsp_addr,
  output logic [N-1:0] rsp_rdata,
  output logic         rf_write_enable,
  output logic [A-1:0] rf_write_addr,
  output logic [N-1:0] rf_write_data,
  output logic [A-1:0] rf_read_addr,
  input  logic [N-1:0] rf_read_data,
  output logic [15:0]  txn_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t       state_q, state_d;
  logic         cmd_write_q, cmd_write_d;
  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_write_q, rsp_write_d;
  logic [A-1:0] rsp_addr_q, rsp_addr_d;
  logic [N-1:0] rsp_rdata_q, rsp_rdata_d;
  logic         rf_write_enable_q, rf_write_enable_d;
  logic [A-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [N-1:0] rf_write_data_q, rf_write_data_d;
  logic [A-1:0] rf_read_addr_q, rf_read_addr_d;
  logic [15:0]  txn_count_q, txn_count_d;
  logic [15:0]  txn_count_inc;

  assign txn_count_inc = (txn_count_q == '1) ? txn_count_q : txn_count_q + 16'd1;

  always_comb begin
    state_d           = state_q;
    cmd_write_d       = cmd_write_q;
    req_ready_d       = req_ready_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_write_d       = rsp_write_q;
    rsp_addr_d        = rsp_addr_q;
    rsp_rdata_d       = rsp_rdata_q;
    rf_write_enable_d = 1'b0;
    rf_write_addr_d   = rf_write_addr_q;
    rf_write_data_d   = rf_write_data_q;
    rf_read_addr_d    = rf_read_addr_q;
    txn_count_d       = txn_count_q;

    unique case (state_q)
      IDLE: begin
        // req_ready rises on the first edge after reset and stays up in IDLE.
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          // The rf_* registers double as the command registers, so the
          // register file sees the command for the whole EXEC cycle.
          state_d           = EXEC;
          req_ready_d       = 1'b0;
          cmd_write_d       = req_write;
          rf_write_enable_d = req_write;
          rf_write_addr_d   = req_addr;
          rf_write_data_d   = req_wdata;
          rf_read_addr_d    = req_addr;
        end
      end

      EXEC: begin
        if (!cmd_write_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_addr_d  = rf_read_addr_q;
          rsp_rdata_d = rf_read_data;
        end else begin
`ifdef REGFILE_INIT_WRITE_ACK_EN
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_addr_d  = rf_write_addr_q;
          rsp_rdata_d = '0;
`else
          state_d     = IDLE;
          req_ready_d = 1'b1;
          txn_count_d = txn_count_inc;
`endif
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          txn_count_d = txn_count_inc;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cmd_write_q       <= 1'b0;
      req_ready_q       <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_write_q       <= 1'b0;
      rsp_addr_q        <= '0;
      rsp_rdata_q       <= '0;
      rf_write_enable_q <= 1'b0;
      rf_write_addr_q   <= '0;
      rf_write_data_q   <= '0;
      rf_read_addr_q    <= '0;
      txn_count_q       <= '0;
    end else begin
      state_q           <= state_d;
      cmd_write_q       <= cmd_write_d;
      req_ready_q       <= req_ready_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_write_q       <= rsp_write_d;
      rsp_addr_q        <= rsp_addr_d;
      rsp_rdata_q       <= rsp_rdata_d;
      rf_write_enable_q <= rf_write_enable_d;
      rf_write_addr_q   <= rf_write_addr_d;
      rf_write_data_q   <= rf_write_data_d;
      rf_read_addr_q    <= rf_read_addr_d;
      txn_count_q       <= txn_count_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_addr        = rsp_addr_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rf_write_enable = rf_write_enable_q;
  assign rf_write_addr   = rf_write_addr_q;
  assign rf_write_data   = rf_write_data_q;
  assign rf_read_addr    = rf_read_addr_q;
  assign txn_count       = txn_count_q;

endmodule

// File: tb/tb_regfile_initiator.sv
// Testbench for regfile_initiator: register file model, table of requests,
// response scoreboard, backpressure, reset-in-EXEC and txn_count saturation.

module tb_regfile_initiator;
  localparam int unsigned N = 8;
  localparam int unsigned M = 4;
  localparam int unsigned A = 2;
`ifdef REGFILE_INIT_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, req_write;
  logic [A-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [A-1:0] rsp_addr;
  logic [N-1:0] rsp_rdata;
  logic         rf_write_enable;
  logic [A-1:0] rf_write_addr, rf_read_addr;
  logic [N-1:0] rf_write_data, rf_read_data;
  logic [15:0]  txn_count;

  always #5 clk = ~clk;

  regfile_initiator #(.N(N), .M(M)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .txn_count(txn_count)
  );

  // Register file model: synchronous write, combinational read.
  logic [N-1:0] mem [M];
  always @(posedge clk) if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
  assign rf_read_data = mem[rf_read_addr];

  typedef struct {
    bit           wr;
    logic [A-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit           wr;
    logic [A-1:0] addr;
    logic [N-1:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   rsp_seen = 0;
  int   posted = 0;
  int   txn_base = 0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int exp_txn();
    int s;
    s = txn_base + rsp_seen + posted;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic run_monitor();
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(mon_e.wr));
          chk("rsp_addr", 32'(rsp_addr), 32'(mon_e.addr));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        end
        rsp_seen++;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_write"}, 32'(rsp_write), 32'd0);
    chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rf_we"}, 32'(rf_write_enable), 32'd0);
    chk({tag, "_rf_waddr"}, 32'(rf_write_addr), 32'd0);
    chk({tag, "_rf_wdata"}, 32'(rf_write_data), 32'd0);
    chk({tag, "_rf_raddr"}, 32'(rf_read_addr), 32'd0);
    chk({tag, "_txn"}, 32'(txn_count), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Issue one request; returns 1ns after the edge that ends its EXEC cycle.
  task automatic do_op(input vec_t v);
    wait_ready();
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    if (!v.wr || ACK)
      sb.push_back('{wr: v.wr, addr: v.addr, rdata: (v.wr ? '0 : v.exp_rdata)});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rf_we", 32'(rf_write_enable), 32'(v.wr));
    if (v.wr) begin
      chk("exec_rf_waddr", 32'(rf_write_addr), 32'(v.addr));
      chk("exec_rf_wdata", 32'(rf_write_data), 32'(v.wdata));
    end else begin
      chk("exec_rf_raddr", 32'(rf_read_addr), 32'(v.addr));
    end
    @(posedge clk); #1;
    chk("post_rf_we", 32'(rf_write_enable), 32'd0);
    if (!v.wr || ACK) begin
      chk("resp_valid", 32'(rsp_valid), 32'd1);
    end else begin
      chk("posted_no_rsp", 32'(rsp_valid), 32'd0);
      chk("posted_ready", 32'(req_ready), 32'd1);
      posted++;
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 8'h05, 8'h00};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 8'h05};
    vecs[2] = '{1'b1, 2'd1, 8'h0A, 8'h00};
    vecs[3] = '{1'b1, 2'd2, 8'hF0, 8'h00};
    vecs[4] = '{1'b0, 2'd1, 8'h00, 8'h0A};
    vecs[5] = '{1'b0, 2'd2, 8'h00, 8'hF0};
    vecs[6] = '{1'b1, 2'd3, 8'hAA, 8'h00};
    vecs[7] = '{1'b0, 2'd3, 8'h00, 8'hAA};

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    fork run_monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(req_ready), 32'd1);

    // Idle with req_valid low: nothing moves.
    @(posedge clk); #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rf_we", 32'(rf_write_enable), 32'd0);

    for (int i = 0; i < 8; i++) do_op(vecs[i]);
    drain();
    chk("txn_after_table", 32'(txn_count), 32'(exp_txn()));

    // Backpressure: response held, stray request ignored.
    rsp_ready = 1'b0;
    do_op('{1'b0, 2'd2, 8'h00, 8'hF0});
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", 32'(rsp_rdata), 32'hF0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rf_we", 32'(rf_write_enable), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    do_op('{1'b0, 2'd2, 8'h00, 8'hF0});
    drain();

    // Reset during EXEC of a write: write abandoned.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rx_exec_we", 32'(rf_write_enable), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_reset_vals("rx");
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b1;
    txn_base = 0 - (rsp_seen + posted);
    #1;
    chk("rx_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rx_ready_after_edge", 32'(req_ready), 32'd1);
    do_op('{1'b0, 2'd1, 8'h00, 8'h0A});
    drain();
    chk("rx_txn", 32'(txn_count), 32'(exp_txn()));

    // Saturation: preload near the top, then keep completing transactions.
    @(posedge clk); #1;
    force dut.txn_count_q = 16'hFFFD;
    #1 release dut.txn_count_q;
    txn_base = 32'hFFFD - (rsp_seen + posted);
    for (int i = 0; i < 4; i++) begin
      do_op('{1'b1, 2'd0, 8'h05, 8'h00});
      drain();
      @(posedge clk); #1;
      chk("sat_txn", 32'(txn_count), 32'(exp_txn()));
    end
    chk("sat_final", 32'(txn_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
